// File: rtl/count_display_decoder_pkg.sv
// Shared types, widths, FSM encodings and the 7-segment font for the count display decoder.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package count_display_decoder_pkg;

    localparam int unsigned CountW = 10;
    localparam int unsigned BcdW   = 4;
    localparam int unsigned ShiftW = CountW + 3 * BcdW;
    localparam int unsigned SegW   = 7;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [3:0] ShiftLast = 4'd9;

    localparam logic [SegW-1:0] SegBlank = 7'h7F;
    localparam logic [SegW-1:0] Seg0     = 7'h40;
    localparam logic [SegW-1:0] Seg1     = 7'h79;
    localparam logic [SegW-1:0] Seg2     = 7'h24;
    localparam logic [SegW-1:0] Seg3     = 7'h30;
    localparam logic [SegW-1:0] Seg4     = 7'h19;
    localparam logic [SegW-1:0] Seg5     = 7'h12;
    localparam logic [SegW-1:0] Seg6     = 7'h02;
    localparam logic [SegW-1:0] Seg7     = 7'h78;
    localparam logic [SegW-1:0] Seg8     = 7'h00;
    localparam logic [SegW-1:0] Seg9     = 7'h10;

    typedef struct packed {
        logic [BcdW-1:0] hund;
        logic [BcdW-1:0] tens;
        logic [BcdW-1:0] ones;
    } bcd3_t;

    // One double-dabble step: correct every BCD nibble >= 5, then shift the whole word.
    function automatic logic [ShiftW-1:0] shift_add3(input logic [ShiftW-1:0] v);
        logic [ShiftW-1:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[CountW + BcdW * i +: BcdW] >= 4'd5) begin
                t[CountW + BcdW * i +: BcdW] = t[CountW + BcdW * i +: BcdW] + 4'd3;
            end
        end
        return {t[ShiftW-2:0], 1'b0};
    endfunction

    function automatic logic [SegW-1:0] seg7_font(input logic [BcdW-1:0] d);
        logic [SegW-1:0] s;
        case (d)
            4'd0:    s = Seg0;
            4'd1:    s = Seg1;
            4'd2:    s = Seg2;
            4'd3:    s = Seg3;
            4'd4:    s = Seg4;
            4'd5:    s = Seg5;
            4'd6:    s = Seg6;
            4'd7:    s = Seg7;
            4'd8:    s = Seg8;
            4'd9:    s = Seg9;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/count_display_decoder_if.sv
// Load/result bus between the counter (master) and the display decoder (slave).
interface count_display_decoder_if;
    import count_display_decoder_pkg::*;

    logic [CountW-1:0] count_in;
    logic              load;
    logic              ready;
    logic [BcdW-1:0]   bcd_hund;
    logic [BcdW-1:0]   bcd_tens;
    logic [BcdW-1:0]   bcd_ones;
    logic              bcd_valid;
    logic              err;

    modport master (
        output count_in,
        output load,
        input  ready,
        input  bcd_hund,
        input  bcd_tens,
        input  bcd_ones,
        input  bcd_valid,
        input  err
    );

    modport slave (
        input  count_in,
        input  load,
        output ready,
        output bcd_hund,
        output bcd_tens,
        output bcd_ones,
        output bcd_valid,
        output err
    );

endinterface

// File: rtl/count_display_decoder_seg7_scanner.sv
// Time-multiplexed 3-digit common-anode driver: scan counter, anode rotation,
// leading-zero blanking and font lookup from the registered BCD digits.
module count_display_decoder_seg7_scanner
    import count_display_decoder_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  bcd3_t           digits,
    output logic [SegW-1:0] seg,
    output logic [2:0]      an
);

    localparam int unsigned     CntW   = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      dig_q, dig_d;
    logic [BcdW-1:0] cur;
    logic            blank;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        dig_d = dig_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            dig_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

    // dig_q: 0 = ones, 1 = tens, 2 = hundreds.
    always_comb begin
        an    = 3'b110;
        cur   = digits.ones;
        blank = 1'b0;
        case (dig_q)
            2'd1: begin
                an    = 3'b101;
                cur   = digits.tens;
                blank = BLANK_LZ && (digits.hund == '0) && (digits.tens == '0);
            end
            2'd2: begin
                an    = 3'b011;
                cur   = digits.hund;
                blank = BLANK_LZ && (digits.hund == '0);
            end
            default: ;
        endcase
        seg = blank ? SegBlank : seg7_font(cur);
    end

endmodule

// File: rtl/count_display_decoder.sv
// Binary 0..MAX_COUNT to 3-digit BCD converter (sequential shift-add-3) feeding a
// multiplexed 7-segment scanner.
module count_display_decoder
    import count_display_decoder_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 999,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter bit          BLANK_LZ  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    count_display_decoder_if.slave bus,
    output logic [SegW-1:0]        seg,
    output logic [2:0]             an
);

    logic [1:0]        state_q, state_d;
    logic [ShiftW-1:0] sreg_q, sreg_d;
    logic [3:0]        scnt_q, scnt_d;
    bcd3_t             bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              ready;
    logic              in_range;

    // The bcd_valid cycle still counts as busy, so a new load lands one cycle later.
    assign ready    = (state_q == StIdle) && !valid_q;
    assign in_range = 32'(bus.count_in) <= MAX_COUNT;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        scnt_d  = scnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.load && ready) begin
                    if (in_range) begin
                        sreg_d  = {{(ShiftW - CountW){1'b0}}, bus.count_in};
                        scnt_d  = 4'd0;
                        state_d = StShift;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StShift: begin
                sreg_d = shift_add3(sreg_q);
                scnt_d = scnt_q + 4'd1;
                if (scnt_q == ShiftLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = sreg_q[ShiftW-1:CountW];
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            scnt_q  <= 4'd0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            scnt_q  <= scnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready     = ready;
    assign bus.bcd_hund  = bcd_q.hund;
    assign bus.bcd_tens  = bcd_q.tens;
    assign bus.bcd_ones  = bcd_q.ones;
    assign bus.bcd_valid = valid_q;
    assign bus.err       = err_q;

    count_display_decoder_seg7_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (BLANK_LZ)
    ) u_scanner (
        .clk     (clk),
        .reset_n (reset_n),
        .digits  (bcd_q),
        .seg     (seg),
        .an      (an)
    );

endmodule

// File: tb/tb_count_display_decoder.sv
// Scoreboard bench: stimulus pushes expected results from a decimal reference model,
// a monitor pops and compares whenever bcd_valid or err fires.
module tb_count_display_decoder;

    typedef struct {
        int hund;
        int tens;
        int ones;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         ready_at = 0;
    exp_t       exp_q[$];
    int         err_q[$];
    int         font[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    count_display_decoder_if bus ();

    count_display_decoder #(
        .MAX_COUNT (999),
        .SCAN_DIV  (4),
        .BLANK_LZ  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int exp_seg(input int idx, input int h, input int t, input int o);
        if (idx == 0) return font[o];
        if (idx == 1) return (h == 0 && t == 0) ? 'h7F : font[t];
        return (h == 0) ? 'h7F : font[h];
    endfunction

    // Called just after a falling edge; the load is seen by the next rising edge e.
    task automatic drive(input int v, output int e);
        exp_t x;
        bus.count_in = v[9:0];
        bus.load     = 1'b1;
        e            = cyc + 1;
        if (e >= ready_at) begin
            if (v <= 999) begin
                x.hund = v / 100;
                x.tens = (v / 10) % 10;
                x.ones = v % 10;
                x.due  = e + 11;
                exp_q.push_back(x);
                ready_at = e + 13;
            end else begin
                err_q.push_back(e);
            end
        end
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < ready_at) @(negedge clk);
    endtask

    task automatic check_scan(input string name, input int h, input int t, input int o);
        logic [2:0] prev;
        int         idx0;
        int         idx;
        bit         moved;
        prev  = an;
        moved = 1'b0;
        for (int i = 0; i < 10 && !moved; i++) begin
            @(negedge clk);
            if (an != prev) moved = 1'b1;
        end
        chk({name, "_scan_moves"}, int'(moved), 1);
        idx0 = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : (an == 3'b011) ? 2 : -1;
        chk({name, "_anode_legal"}, int'(idx0 >= 0), 1);
        if (idx0 < 0) idx0 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            idx = (idx0 + k / 4) % 3;
            chk({name, "_an"}, int'(an), int'(~(3'b001 << idx) & 3'b111));
            chk({name, "_seg"}, int'(seg), exp_seg(idx, h, t, o));
        end
    endtask

    // Monitor: compares every DUT result against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (reset_n) begin
            if (bus.bcd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bcd_valid got=%0d/%0d/%0d want=none (cycle %0d)",
                             bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.bcd_hund != 4'(e.hund) || bus.bcd_tens != 4'(e.tens) ||
                        bus.bcd_ones != 4'(e.ones) || cyc != e.due) begin
                        errors++;
                        $display("FAIL bcd_result got=%0d/%0d/%0d@%0d want=%0d/%0d/%0d@%0d",
                                 bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, cyc,
                                 e.hund, e.tens, e.ones, e.due);
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_bcd_valid got=none want=%0d/%0d/%0d@%0d",
                         e.hund, e.tens, e.ones, e.due);
            end
            if (bus.err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err got=1@%0d want=0", cyc);
                end else begin
                    d = err_q.pop_front();
                    if (cyc != d) begin
                        errors++;
                        $display("FAIL err_timing got=%0d want=%0d", cyc, d);
                    end
                end
            end else if (err_q.size() > 0 && cyc > err_q[0]) begin
                d = err_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_err got=none want=1@%0d", d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int e2;
        int v;
        bus.count_in = '0;
        bus.load     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_bcd", int'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 0);
        chk("rst_valid", int'(bus.bcd_valid), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_an", int'(an), 'b110);
        chk("rst_seg", int'(seg), 'h40);
        reset_n = 1'b1;
        @(negedge clk);

        drive(999, e);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("busy_ready", int'(bus.ready), 0);
        end
        @(negedge clk);
        chk("ready_back", int'(bus.ready), 1);

        wait_idle();
        drive(100, e);
        while (cyc < e + 12) @(negedge clk);
        check_scan("show100", 1, 0, 0);
        wait_idle();
        drive(7, e);
        while (cyc < e + 12) @(negedge clk);
        check_scan("show7", 0, 0, 7);

        wait_idle();
        drive(42, e);
        while (cyc < e + 12) @(negedge clk);
        check_scan("show42", 0, 4, 2);
        wait_idle();
        drive(1000, e);
        chk("err_ready", int'(bus.ready), 1);
        chk("err_bcd_kept", int'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 'h042);

        wait_idle();
        drive(512, e);
        while (cyc + 1 < e + 5) @(negedge clk);
        drive(3, e2);
        wait_idle();

        drive(856, e);
        while (cyc < e + 5) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        err_q.delete();
        ready_at = 0;
        #1;
        chk("abort_ready", int'(bus.ready), 1);
        chk("abort_bcd", int'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 0);
        chk("abort_valid", int'(bus.bcd_valid), 0);
        chk("abort_an_seg", int'({an, seg}), int'({3'b110, 7'h40}));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(856, e);
        while (cyc < e + 12) @(negedge clk);
        check_scan("show856", 8, 5, 6);
        wait_idle();
        drive(239, e);
        while (cyc < e + 12) @(negedge clk);
        check_scan("show239", 2, 3, 9);

        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 999);
            drive(v, e);
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
